// File: rtl/lsu_access_ctrl_if.sv
// lsu_access_ctrl_if: request/response handshake between the execute stage and the load/store controller.
interface lsu_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: load/store controller that maps funct3 to memory masks and splits misaligned accesses into bytes.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err instead of splitting them.
module lsu_access_ctrl #(
    parameter int MEM_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_access_ctrl_if.slave      bus,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_mask,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, SPLIT = 2'd2, FINISH = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  n_q, n_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [2:0]  n_in;
    logic        illegal, out_of_range, misaligned, active;
    logic [2:0]  rd_mask, wr_mask;
    logic [31:0] asm_nx, asm_ext, wdata_sh;

    assign n_in         = bus.req_funct3[1:0] == 2'b00 ? 3'd1 : bus.req_funct3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    assign illegal      = bus.req_funct3[1:0] == 2'b11 ||
                          (bus.req_we ? bus.req_funct3[2] : bus.req_funct3[2:1] == 2'b11);
    // 33-bit sum so an access near 2^32 cannot wrap back into range
    assign out_of_range = ({1'b0, bus.req_addr} + {30'b0, n_in} - 33'd1) >= 33'(MEM_BYTES);
    assign misaligned   = (n_in == 3'd2 && bus.req_addr[0]) || (n_in == 3'd4 && bus.req_addr[1:0] != 2'b00);

    assign rd_mask  = f3_q == 3'b000 ? 3'b011 : f3_q == 3'b001 ? 3'b001 :
                      f3_q == 3'b010 ? 3'b000 : f3_q == 3'b100 ? 3'b100 : 3'b010;
    assign wr_mask  = f3_q[1:0] == 2'b00 ? 3'b010 : f3_q[1:0] == 2'b01 ? 3'b001 : 3'b000;
    assign asm_nx   = asm_q | ({24'b0, mem_rdata[7:0]} << {idx_q, 3'b000});
    assign asm_ext  = f3_q[1] ? asm_nx : f3_q[2] ? {16'b0, asm_nx[15:0]} : {{16{asm_nx[15]}}, asm_nx[15:0]};
    assign wdata_sh = wdata_q >> {idx_q, 3'b000};

    assign active    = state_q == ACCESS || state_q == SPLIT;
    assign mem_rd_en = active && !we_q;
    assign mem_wr_en = active && we_q;
    assign mem_mask  = state_q == ACCESS ? (we_q ? wr_mask : rd_mask) :
                       state_q == SPLIT  ? (we_q ? 3'b010 : 3'b100) : 3'b000;
    assign mem_addr  = state_q == ACCESS ? addr_q : state_q == SPLIT ? addr_q + {30'b0, idx_q} : 32'b0;
    assign mem_wdata = !(active && we_q) ? 32'b0 : state_q == ACCESS ? wdata_q : {24'b0, wdata_sh[7:0]};

    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        n_d          = n_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                f3_d    = bus.req_funct3;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                n_d     = n_in;
                idx_d   = 2'd0;
                asm_d   = 32'b0;
                if (illegal || out_of_range) begin
                    state_d      = FINISH;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else if (misaligned) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d      = FINISH;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
`else
                    state_d      = SPLIT;
`endif
                end else begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d      = FINISH;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? 32'b0 : mem_rdata;
            end
`ifndef LSU_MISALIGN_TRAP_EN
            SPLIT: begin
                asm_d = asm_nx;
                idx_d = idx_q + 2'd1;
                if ({1'b0, idx_q} + 3'd1 == n_q) begin
                    state_d      = FINISH;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'b0 : asm_ext;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b0;
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            n_q          <= 3'b0;
            idx_q        <= 2'b0;
            asm_q        <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end
endmodule
